sata_fis_router: RTL and testbench
==================================

Name: sata_fis_router

Overview:
- Receive-side counterpart of the transmit FIS arbiter: one incoming SATA FIS stream is split into two outgoing streams.
- The FIS type is the low byte of the first dword of each frame.
- Data FIS (0x46) frames go to output #2, the DMA data path. Every other known FIS type goes to output #1, the command/register path.
- Frames with an unknown type are consumed and discarded, and counted.
- The block sits between the link-layer receive path and the transport layer.

Parameters:
- DATA_FIS_TYPE, 8'h46, FIS type routed to output #2.
- CNT_WIDTH, 16, width of the saturating dropped-frame counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_dat  input  32  input FIS stream data
- i_val  input  1  input word valid
- i_eop  input  1  input last word of frame
- i_rdy  output  1  input ready
- o1_dat  output  32  output #1 (non-data FIS) data
- o1_val  output  1  output #1 valid
- o1_eop  output  1  output #1 end of frame
- o1_rdy  input  1  output #1 ready
- o2_dat  output  32  output #2 (Data FIS) data
- o2_val  output  1  output #2 valid
- o2_eop  output  1  output #2 end of frame
- o2_rdy  input  1  output #2 ready
- drop_pulse  output  1  one-cycle strobe, unknown-type frame start accepted
- drop_cnt  output  CNT_WIDTH  saturating count of dropped frames

Behaviour:
- One clock (clk). Synchronous active-high reset (reset). All state changes on posedge clk only.
- Transfer rule: a word moves on any interface when val & rdy are both high in the same cycle.
- Known types: 0x27, 0x34, 0x39, 0x41, 0x46, 0x58, 0x5F, 0xA1. All other values are unknown.
- FSM states: ST_SOP, ST_FWD1, ST_FWD2, ST_DROP. Reset state is ST_SOP.
- In ST_SOP the target is decoded combinationally from i_dat[7:0]:
  - DATA_FIS_TYPE -> port 2.
  - Other known type -> port 1.
  - Unknown type -> drop.
- On an accepted word in ST_SOP:
  - If i_eop = 1, stay in ST_SOP (single-dword FIS).
  - Otherwise go to ST_FWD1, ST_FWD2 or ST_DROP according to the target.
- In ST_FWDx / ST_DROP, an accepted word with i_eop = 1 returns the FSM to ST_SOP. The target is latched for the whole frame and never re-decoded mid-frame.
- Each output has a one-entry register slice:
  - Latency is exactly 1 cycle from input acceptance to oN_val.
  - Slice ready = ~oN_val | oN_rdy, giving full throughput of 1 word/cycle.
  - oN_dat / oN_eop hold stable while oN_val & ~oN_rdy.
- i_rdy:
  - Forwarding to port N: i_rdy = slice N ready.
  - Drop target: i_rdy = 1.
  - i_rdy may depend combinationally on i_val / i_dat in ST_SOP.
- Output slices are independent. A stalled o1 word does not block a following frame routed to o2, and vice versa.
- Drop path: drop_pulse = 1 for exactly the cycle the first word of an unknown frame is accepted. drop_cnt increments in that same cycle and saturates at all-ones.
- No output port ever sees a word of a dropped frame.
- i_val low mid-frame: the FSM holds its state; no timeout.
- Reset values: o1_val = o2_val = 0; o1_dat = o2_dat = 0; o1_eop = o2_eop = 0; drop_pulse = 0; drop_cnt = 0; FSM = ST_SOP.
- Reset mid-frame: any slice contents are discarded and the partial frame is not completed. The first word accepted after reset is treated as a frame start.

Decomposition:
- Package sata_fis_pkg holds:
  - the localparam FIS type codes (FIS_H2D_REG = 8'h27, FIS_D2H_REG = 8'h34, FIS_DMA_ACT = 8'h39, FIS_DMA_SETUP = 8'h41, FIS_DATA = 8'h46, FIS_BIST = 8'h58, FIS_PIO_SETUP = 8'h5F, FIS_SDB = 8'hA1);
  - the router state enum;
  - a function returning whether a type code is known.
- Sub-module sata_fis_reg_slice: a one-entry dat/val/eop register slice with rdy pass-through logic, instantiated once per output.

Test Plan:
- 5-word frame with first dword 0x00000046, o1_rdy = o2_rdy = 1 -> 5 words on o2 starting 1 cycle after acceptance, o2_eop on the 5th; o1_val stays 0.
- Single-word frame 0x00000034 with i_eop = 1, then immediately a 0x46 frame -> 1 word on o1 with o1_eop = 1, then the data frame on o2 back-to-back with no bubble.
- 3-word frame with type 0x99 -> i_rdy = 1 throughout, no oN_val, drop_pulse high for 1 cycle, drop_cnt 0 -> 1.
- o1_rdy held 0 while o1 holds the last word of a 0x27 frame; next frame 0x46 arrives -> that frame streams on o2 unblocked, o1 word held stable until o1_rdy = 1.
- 0x46 frame with o2_rdy toggling 1010… and i_val gaps -> all words delivered in order, no duplication or loss, i_rdy low exactly when the slice is full and o2_rdy = 0.
- reset asserted after word 2 of a 6-word 0x41 frame, then a new 2-word 0x5F frame -> outputs cleared, 0x5F frame appears intact on o1, and drop_cnt is still 0 after reset.

Source files
------------

// File: rtl/sata_fis_pkg.sv
// Shared FIS type codes, router state encoding and type-classification helper
// for the SATA receive-side FIS router.
package sata_fis_pkg;

    localparam logic [7:0] FIS_H2D_REG   = 8'h27;
    localparam logic [7:0] FIS_D2H_REG   = 8'h34;
    localparam logic [7:0] FIS_DMA_ACT   = 8'h39;
    localparam logic [7:0] FIS_DMA_SETUP = 8'h41;
    localparam logic [7:0] FIS_DATA      = 8'h46;
    localparam logic [7:0] FIS_BIST      = 8'h58;
    localparam logic [7:0] FIS_PIO_SETUP = 8'h5F;
    localparam logic [7:0] FIS_SDB       = 8'hA1;

    typedef enum logic [1:0] {
        ST_SOP,
        ST_FWD1,
        ST_FWD2,
        ST_DROP
    } router_state_t;

    typedef enum logic [1:0] {
        RT_DROP,
        RT_PORT1,
        RT_PORT2
    } route_t;

    function automatic logic fis_type_known(input logic [7:0] fis_type);
        case (fis_type)
            FIS_H2D_REG, FIS_D2H_REG, FIS_DMA_ACT, FIS_DMA_SETUP,
            FIS_DATA, FIS_BIST, FIS_PIO_SETUP, FIS_SDB: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sata_fis_reg_slice.sv
// One-entry register slice: one cycle of latency, full throughput because the
// entry can be refilled in the same cycle it is consumed.
module sata_fis_reg_slice #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              in_val,
    input  logic              in_eop,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_val,
    output logic              out_eop,
    input  logic              out_rdy
);

    logic [DATA_W-1:0] dat_p1;
    logic              eop_p1;
    logic              vld_p1;

    assign in_rdy = ~vld_p1 | out_rdy;

    // stage p1: held entry, only replaced on a load so it stays stable under stall
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            dat_p1 <= '0;
            eop_p1 <= 1'b0;
        end else if (in_val && in_rdy) begin
            vld_p1 <= 1'b1;
            dat_p1 <= in_dat;
            eop_p1 <= in_eop;
        end else if (out_rdy) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_dat = dat_p1;
    assign out_val = vld_p1;
    assign out_eop = eop_p1;

endmodule

// File: rtl/sata_fis_router.sv
// Splits the received FIS stream: Data FIS frames to output 2, other known FIS
// types to output 1, unknown types swallowed and counted.
module sata_fis_router
    import sata_fis_pkg::*;
#(
    parameter logic [7:0] DATA_FIS_TYPE = FIS_DATA,
    parameter int         CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          i_dat,
    input  logic                 i_val,
    input  logic                 i_eop,
    output logic                 i_rdy,
    output logic [31:0]          o1_dat,
    output logic                 o1_val,
    output logic                 o1_eop,
    input  logic                 o1_rdy,
    output logic [31:0]          o2_dat,
    output logic                 o2_val,
    output logic                 o2_eop,
    input  logic                 o2_rdy,
    output logic                 drop_pulse,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    router_state_t state_p0, state_nxt;
    route_t        route;
    logic          accept;
    logic          s1_val, s1_rdy;
    logic          s2_val, s2_rdy;

    // Mid-frame the target comes from the latched state; only SOP decodes i_dat.
    always_comb begin
        route = RT_DROP;
        case (state_p0)
            ST_FWD1: route = RT_PORT1;
            ST_FWD2: route = RT_PORT2;
            ST_DROP: route = RT_DROP;
            default: begin
                if (i_dat[7:0] == DATA_FIS_TYPE)
                    route = RT_PORT2;
                else if (fis_type_known(i_dat[7:0]))
                    route = RT_PORT1;
                else
                    route = RT_DROP;
            end
        endcase
    end

    always_comb begin
        case (route)
            RT_PORT1: i_rdy = s1_rdy;
            RT_PORT2: i_rdy = s2_rdy;
            default:  i_rdy = 1'b1;
        endcase
    end

    assign accept     = i_val & i_rdy;
    assign s1_val     = i_val & (route == RT_PORT1);
    assign s2_val     = i_val & (route == RT_PORT2);
    assign drop_pulse = accept & (state_p0 == ST_SOP) & (route == RT_DROP) & ~reset;

    always_comb begin
        state_nxt = state_p0;
        if (accept) begin
            case (state_p0)
                ST_SOP: begin
                    if (!i_eop) begin
                        case (route)
                            RT_PORT1: state_nxt = ST_FWD1;
                            RT_PORT2: state_nxt = ST_FWD2;
                            default:  state_nxt = ST_DROP;
                        endcase
                    end
                end
                default: begin
                    if (i_eop)
                        state_nxt = ST_SOP;
                end
            endcase
        end
    end

    // stage p0: frame state and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0 <= ST_SOP;
            drop_cnt <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (drop_pulse && (drop_cnt != {CNT_WIDTH{1'b1}}))
                drop_cnt <= drop_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    sata_fis_reg_slice #(.DATA_W(32)) u_slice1 (
        .clk     (clk),
        .reset   (reset),
        .in_dat  (i_dat),
        .in_val  (s1_val),
        .in_eop  (i_eop),
        .in_rdy  (s1_rdy),
        .out_dat (o1_dat),
        .out_val (o1_val),
        .out_eop (o1_eop),
        .out_rdy (o1_rdy)
    );

    sata_fis_reg_slice #(.DATA_W(32)) u_slice2 (
        .clk     (clk),
        .reset   (reset),
        .in_dat  (i_dat),
        .in_val  (s2_val),
        .in_eop  (i_eop),
        .in_rdy  (s2_rdy),
        .out_dat (o2_dat),
        .out_val (o2_val),
        .out_eop (o2_eop),
        .out_rdy (o2_rdy)
    );

endmodule

// File: tb/tb_sata_fis_router.sv
// Randomized scoreboard bench for sata_fis_router with a frame-level reference model.
module tb_sata_fis_router;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_dat = '0;
    logic        i_val = 1'b0;
    logic        i_eop = 1'b0;
    logic        i_rdy;
    logic [31:0] o1_dat, o2_dat;
    logic        o1_val, o1_eop, o2_val, o2_eop;
    logic        o1_rdy = 1'b1;
    logic        o2_rdy = 1'b1;
    logic        drop_pulse;
    logic [15:0] drop_cnt;

    sata_fis_router dut (
        .clk        (clk),
        .reset      (reset),
        .i_dat      (i_dat),
        .i_val      (i_val),
        .i_eop      (i_eop),
        .i_rdy      (i_rdy),
        .o1_dat     (o1_dat),
        .o1_val     (o1_val),
        .o1_eop     (o1_eop),
        .o1_rdy     (o1_rdy),
        .o2_dat     (o2_dat),
        .o2_val     (o2_val),
        .o2_eop     (o2_eop),
        .o2_rdy     (o2_rdy),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          in_reset = 1'b1;
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    int          lat_port[int];
    bit          m_in_frame = 1'b0;
    int          m_route = 0;
    int          exp_drops = 0;
    int          mode1 = 0;
    int          mode2 = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 0 = always ready, 1 = random, 2 = toggle, 3 = held low
    initial forever begin
        @(posedge clk);
        #1;
        case (mode1)
            0: o1_rdy = 1'b1;
            1: o1_rdy = 1'($urandom_range(0, 1));
            2: o1_rdy = ~o1_rdy;
            default: o1_rdy = 1'b0;
        endcase
        case (mode2)
            0: o2_rdy = 1'b1;
            1: o2_rdy = 1'($urandom_range(0, 1));
            2: o2_rdy = ~o2_rdy;
            default: o2_rdy = 1'b0;
        endcase
    end

    function automatic int route_of(input logic [7:0] t);
        case (t)
            8'h46: return 2;
            8'h27, 8'h34, 8'h39, 8'h41, 8'h58, 8'h5F, 8'hA1: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [31:0] d, input logic eop);
        if (!m_in_frame) begin
            m_route = route_of(d[7:0]);
            if (m_route == 0 && exp_drops < 65535)
                exp_drops++;
        end
        if (m_route == 1) begin
            q1.push_back({eop, d});
            lat_port[cyc] = 1;
        end else if (m_route == 2) begin
            q2.push_back({eop, d});
            lat_port[cyc] = 2;
        end
        m_in_frame = !eop;
    endtask

    // Monitor: pops expected words whenever an output transfer is about to occur.
    initial begin
        logic        p1s, p2s;
        logic [32:0] pv1, pv2, e;
        p1s = 1'b0;
        p2s = 1'b0;
        pv1 = '0;
        pv2 = '0;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                p1s = 1'b0;
                p2s = 1'b0;
                continue;
            end
            if (lat_port.exists(cyc - 1)) begin
                if (lat_port[cyc - 1] == 1) chk("latency_o1", o1_val, 1);
                else                        chk("latency_o2", o2_val, 1);
                lat_port.delete(cyc - 1);
            end
            if (p1s) chk("hold_o1", {o1_val, o1_eop, o1_dat}, {1'b1, pv1});
            if (p2s) chk("hold_o2", {o2_val, o2_eop, o2_dat}, {1'b1, pv2});
            if (o1_val && o1_rdy) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_o1: got %0h expected no word", {o1_eop, o1_dat});
                end else begin
                    e = q1.pop_front();
                    chk("o1_word", {o1_eop, o1_dat}, e);
                end
            end
            if (o2_val && o2_rdy) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_o2: got %0h expected no word", {o2_eop, o2_dat});
                end else begin
                    e = q2.pop_front();
                    chk("o2_word", {o2_eop, o2_dat}, e);
                end
            end
            p1s = o1_val && !o1_rdy;
            p2s = o2_val && !o2_rdy;
            pv1 = {o1_eop, o1_dat};
            pv2 = {o2_eop, o2_dat};
        end
    end

    // Entered and left at posedge+1.
    task automatic send_frame(input logic [7:0] typ, input int len, input int gap_pct,
                              input int abort_after);
        logic [31:0] d;
        int          r, t;
        logic        exp_rdy;
        for (int w = 0; w < len; w++) begin
            d = $urandom;
            if (w == 0) d[7:0] = typ;
            i_dat = d;
            i_val = 1'b1;
            i_eop = (w == len - 1);
            t = 0;
            r = 0;
            forever begin
                @(negedge clk);
                r = m_in_frame ? m_route : route_of(i_dat[7:0]);
                exp_rdy = (r == 0) ? 1'b1 : (r == 1) ? (!o1_val || o1_rdy) : (!o2_val || o2_rdy);
                chk("i_rdy", i_rdy, exp_rdy);
                if (i_rdy) break;
                chk("drop_pulse_idle", drop_pulse, 0);
                t++;
                if (t > 2000) begin
                    $display("FAIL input_stall_timeout: got i_rdy low for %0d cycles expected progress", t);
                    $fatal(1, "input stalled");
                end
            end
            chk("drop_pulse", drop_pulse, (!m_in_frame && r == 0) ? 1 : 0);
            model_accept(d, i_eop);
            @(posedge clk);
            #1;
            i_val = 1'b0;
            i_eop = 1'b0;
            if (abort_after != 0 && w + 1 == abort_after) return;
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                i_dat = $urandom;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        mode1 = 0;
        mode2 = 0;
        t = 0;
        while ((q1.size() != 0 || q2.size() != 0 || o1_val || o2_val) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", q1.size() + q2.size(), 0);
        chk("drop_cnt", drop_cnt, exp_drops);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_reset = 1'b1;
        reset = 1'b1;
        i_val = 1'b0;
        i_eop = 1'b0;
        q1.delete();
        q2.delete();
        lat_port.delete();
        m_in_frame = 1'b0;
        exp_drops = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_o1_val", o1_val, 0);
        chk("rst_o2_val", o2_val, 0);
        chk("rst_o1_dat", o1_dat, 0);
        chk("rst_o2_dat", o2_dat, 0);
        chk("rst_o1_eop", o1_eop, 0);
        chk("rst_o2_eop", o2_eop, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_reset = 1'b0;
    endtask

    initial begin
        logic [7:0] typ_tbl[12];
        typ_tbl = '{8'h27, 8'h34, 8'h39, 8'h41, 8'h46, 8'h58, 8'h5F, 8'hA1,
                    8'h99, 8'h00, 8'hFF, 8'h45};
        apply_reset();

        // data frame straight through to o2
        send_frame(8'h46, 5, 0, 0);
        drain();

        // single-dword register FIS then back-to-back data frame
        send_frame(8'h34, 1, 0, 0);
        send_frame(8'h46, 3, 0, 0);
        drain();

        // unknown type is swallowed and counted
        send_frame(8'h99, 3, 0, 0);
        drain();

        // o1 stalled on the last word of a frame must not block o2 traffic
        mode1 = 3;
        o1_rdy = 1'b0;
        send_frame(8'h27, 1, 0, 0);
        send_frame(8'h46, 4, 0, 0);
        @(negedge clk);
        chk("stalled_o1_val", o1_val, 1);
        chk("stalled_o1_type", o1_dat[7:0], 8'h27);
        @(posedge clk);
        #1;
        drain();

        // toggling backpressure with input gaps
        mode2 = 2;
        send_frame(8'h46, 8, 50, 0);
        drain();

        // reset in the middle of a frame
        send_frame(8'h41, 6, 0, 2);
        apply_reset();
        send_frame(8'h5F, 2, 0, 0);
        drain();

        // random traffic
        for (int f = 0; f < 150; f++) begin
            mode1 = int'($urandom_range(0, 2));
            mode2 = int'($urandom_range(0, 2));
            send_frame(typ_tbl[$urandom_range(0, 11)], int'($urandom_range(1, 8)), 30, 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
